iir_tap_sequencer: RTL and testbench

- Control and datapath stage directly upstream of the mac accumulator in the IIR filter.
- Accepts one input sample at a time and keeps the x and y delay lines plus a writable coefficient bank.
- Feeds coefficient/sample operand pairs into mac through its start/ready handshake, then reads the accumulated sum back.
- Produces each scaled, saturated output sample y[n], which also feeds the recursive y history.

---
 rtl/iir_tap_sequencer.sv | 129 ++++++++++++
 tb/tb_iir_tap_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_tap_sequencer.sv
// Tap sequencer for the IIR filter: walks b/a taps through the external mac
// handshake, then scales and saturates the accumulated sum into y[n].
module iir_tap_sequencer #(
  parameter int opsize = 8,
  parameter int NB     = 3,
  parameter int NA     = 2,
  parameter int FRAC   = 6,
  localparam int NT    = NB + NA,
  localparam int AW    = $clog2(NT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [opsize-1:0]     x_in,
  input  logic                  x_valid,
  output logic                  x_ready,
  input  logic                  coef_wr_en,
  input  logic [AW-1:0]         coef_wr_addr,
  input  logic [opsize-1:0]     coef_wr_data,
  output logic [opsize-1:0]     mac_A,
  output logic [opsize-1:0]     mac_B,
  output logic                  mac_start,
  output logic                  mac_reset,
  input  logic                  mac_ready,
  input  logic [2*opsize-1:0]   mac_out,
  output logic [opsize-1:0]     y_out,
  output logic                  y_valid
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] CLEAR     = 3'd1;
  localparam logic [2:0] ISSUE     = 3'd2;
  localparam logic [2:0] WAIT_BUSY = 3'd3;
  localparam logic [2:0] WAIT_DONE = 3'd4;
  localparam logic [2:0] SETTLE    = 3'd5;
  localparam logic [2:0] OUTPUT    = 3'd6;

  localparam logic signed [2*opsize-1:0] YMAX = {{(opsize+1){1'b0}}, {(opsize-1){1'b1}}};
  localparam logic signed [2*opsize-1:0] YMIN = {{(opsize+1){1'b1}}, {(opsize-1){1'b0}}};

  logic [2:0]                  state;
  logic [AW-1:0]               k;
  logic [NT-1:0][opsize-1:0]   coef;    // b0..b(NB-1), then a1..aNA
  logic [NB-1:0][opsize-1:0]   x_hist;  // x_hist[i] = x[n-i]
  logic [NA-1:0][opsize-1:0]   y_hist;  // y_hist[j] = y[n-1-j]
  logic [opsize-1:0]           tap_coef, tap_sample, y_sat;
  logic signed [2*opsize-1:0]  acc, shifted;

  assign x_ready   = (state == IDLE);
  assign mac_reset = reset || (state == CLEAR);

  always_comb begin
    tap_coef   = '0;
    tap_sample = '0;
    for (int i = 0; i < NT; i++)
      if (k == AW'(i)) tap_coef = coef[i];
    for (int i = 0; i < NB; i++)
      if (k == AW'(i)) tap_sample = x_hist[i];
    for (int j = 0; j < NA; j++)
      if (k == AW'(NB + j)) tap_sample = y_hist[j];
  end

  assign acc     = signed'(mac_out);
  assign shifted = acc >>> FRAC;

  always_comb begin
    if (shifted > YMAX)      y_sat = {1'b0, {(opsize-1){1'b1}}};
    else if (shifted < YMIN) y_sat = {1'b1, {(opsize-1){1'b0}}};
    else                     y_sat = shifted[opsize-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      k         <= '0;
      coef      <= '0;
      x_hist    <= '0;
      y_hist    <= '0;
      y_out     <= '0;
      y_valid   <= 1'b0;
      mac_start <= 1'b0;
      mac_A     <= '0;
      mac_B     <= '0;
    end else begin
      y_valid   <= 1'b0;
      mac_start <= 1'b0;
      case (state)
        IDLE: begin
          // Out-of-range addresses match no slot and fall through.
          if (coef_wr_en)
            for (int i = 0; i < NT; i++)
              if (coef_wr_addr == AW'(i)) coef[i] <= coef_wr_data;
          if (x_valid) begin
            x_hist[0] <= x_in;
            k         <= '0;
            state     <= CLEAR;
          end
        end
        CLEAR: state <= ISSUE;
        ISSUE: begin
          if (mac_ready) begin
            mac_A     <= tap_coef;
            mac_B     <= tap_sample;
            mac_start <= 1'b1;
            state     <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: if (!mac_ready) state <= WAIT_DONE;
        WAIT_DONE: if (mac_ready)  state <= SETTLE;
        SETTLE: begin
          if (k == AW'(NT - 1)) state <= OUTPUT;
          else begin
            k     <= k + 1'b1;
            state <= ISSUE;
          end
        end
        OUTPUT: begin
          y_out   <= y_sat;
          y_valid <= 1'b1;
          for (int i = 1; i < NB; i++) x_hist[i] <= x_hist[i-1];
          for (int j = 1; j < NA; j++) y_hist[j] <= y_hist[j-1];
          y_hist[0] <= y_sat;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_tap_sequencer.sv
// Bench for iir_tap_sequencer: behavioural mac with random latency, table vectors,
// handshake corner sequences and a randomized run against an arithmetic filter model.
module tb_iir_tap_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  x_in;
  logic        x_valid;
  logic        x_ready;
  logic        coef_wr_en;
  logic [2:0]  coef_wr_addr;
  logic [7:0]  coef_wr_data;
  logic [7:0]  mac_A, mac_B;
  logic        mac_start, mac_reset;
  logic        mac_ready = 1'b1;
  logic signed [15:0] mac_acc = '0;
  logic signed [15:0] mac_prod = '0;
  int          mac_cnt = 0;
  logic [7:0]  y_out;
  logic        y_valid;

  int checks = 0, errors = 0;
  int n_start = 0, n_yv = 0, s_base = 0, clr_seen = 0;
  int mc[5];
  int xh[3];
  int yh[2];

  iir_tap_sequencer dut (
    .clk(clk), .reset(reset), .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready),
    .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data),
    .mac_A(mac_A), .mac_B(mac_B), .mac_start(mac_start), .mac_reset(mac_reset),
    .mac_ready(mac_ready), .mac_out(mac_acc), .y_out(y_out), .y_valid(y_valid)
  );

  always #5 clk = ~clk;

  // mac stand-in: drops ready on start, stays busy a random few cycles, then accumulates
  always @(posedge clk) begin
    if (mac_reset) begin
      mac_acc   <= '0;
      mac_ready <= 1'b1;
      mac_cnt   <= 0;
    end else if (mac_ready && mac_start) begin
      mac_prod  <= $signed(mac_A) * $signed(mac_B);
      mac_cnt   <= int'($urandom_range(0, 3));
      mac_ready <= 1'b0;
    end else if (!mac_ready) begin
      if (mac_cnt == 0) begin
        mac_acc   <= mac_acc + mac_prod;
        mac_ready <= 1'b1;
      end else mac_cnt <= mac_cnt - 1;
    end
  end

  always @(negedge clk) begin
    if (mac_reset && !reset && n_start == s_base) clr_seen = 1;
    if (mac_start) n_start++;
    if (y_valid) n_yv++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 5; i++) mc[i] = 0;
    for (int i = 0; i < 3; i++) xh[i] = 0;
    for (int i = 0; i < 2; i++) yh[i] = 0;
  endfunction

  // y[n] = sat((wrap16(sum b*x + sum a*y)) >>> 6)
  function automatic int model_step(input int x);
    int acc, s, y;
    logic [31:0] accv;
    logic signed [15:0] w;
    xh[2] = xh[1]; xh[1] = xh[0]; xh[0] = x;
    acc = 0;
    for (int i = 0; i < 3; i++) acc += mc[i] * xh[i];
    for (int j = 0; j < 2; j++) acc += mc[3+j] * yh[j];
    accv = acc;
    w = accv[15:0];
    s = int'(w) >>> 6;
    y = (s > 127) ? 127 : (s < -128) ? -128 : s;
    yh[1] = yh[0]; yh[0] = y;
    return y;
  endfunction

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    model_clear();
  endtask

  task automatic wr_coef(input int a, input int d);
    coef_wr_en = 1'b1; coef_wr_addr = a[2:0]; coef_wr_data = d[7:0];
    @(negedge clk) coef_wr_en = 1'b0;
    if (a < 5) mc[a] = d;
  endtask

  task automatic send_x(input int x);
    for (int i = 0; i < 200 && !x_ready; i++) @(negedge clk);
    chk("x_ready_wait", int'(x_ready), 1);
    s_base = n_start; clr_seen = 0;
    x_valid = 1'b1; x_in = x[7:0];
    @(negedge clk) x_valid = 1'b0;
  endtask

  task automatic get_y(output int y);
    int got, yv0;
    logic [7:0] yo;
    got = 0;
    yv0 = n_yv;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (y_valid) begin got = 1; break; end
    end
    chk("y_valid_seen", got, 1);
    y  = int'($signed(y_out));
    yo = y_out;
    chk("mac_starts", n_start - s_base, 5);
    chk("mac_reset_before_start", clr_seen, 1);
    @(negedge clk);
    chk("y_valid_pulse", int'(y_valid), 0);
    chk("y_valid_count", n_yv - yv0, 1);
    chk("y_hold", int'(y_out), int'(yo));
  endtask

  typedef struct {
    bit rst;
    int c0, c1, c2, c3, c4;
    int x;
    int y;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int y, yv0;
    reset = 1'b1; x_valid = 1'b0; x_in = '0;
    coef_wr_en = 1'b0; coef_wr_addr = '0; coef_wr_data = '0;
    model_clear();

    vecs[0] = '{1, 64,   0, 0,  0, 0,   48,   48};
    vecs[1] = '{1, 64,   0, 0, 32, 0,   64,   64};
    vecs[2] = '{0, 0,    0, 0,  0, 0,    0,   32};
    vecs[3] = '{0, 0,    0, 0,  0, 0,    0,   16};
    vecs[4] = '{0, 0,    0, 0,  0, 0,    0,    8};
    vecs[5] = '{1, 127, 127, 0, 0, 0,  100,  127};
    vecs[6] = '{0, 0,    0, 0,  0, 0,  100,  127};
    vecs[7] = '{1, 127,  0, 0,  0, 0, -128, -128};
    vecs[8] = '{1, 32,  32, 0,  0, 0,   10,    5};
    vecs[9] = '{0, 0,    0, 0,  0, 0,   20,   15};

    repeat (2) @(negedge clk);
    chk("rst_mac_reset", int'(mac_reset), 1);
    chk("rst_x_ready", int'(x_ready), 1);
    chk("rst_y_out", int'(y_out), 0);
    chk("rst_y_valid", int'(y_valid), 0);
    chk("rst_mac_start", int'(mac_start), 0);
    chk("rst_mac_A", int'(mac_A), 0);
    chk("rst_mac_B", int'(mac_B), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_mac_reset", int'(mac_reset), 0);

    foreach (vecs[v]) begin
      if (vecs[v].rst) begin
        do_reset();
        wr_coef(0, vecs[v].c0); wr_coef(1, vecs[v].c1); wr_coef(2, vecs[v].c2);
        wr_coef(3, vecs[v].c3); wr_coef(4, vecs[v].c4);
      end
      send_x(vecs[v].x);
      get_y(y);
      chk($sformatf("vec%0d_y", v), y, vecs[v].y);
    end

    // coefficient write while the mac is busy is ignored; in IDLE it lands
    do_reset();
    wr_coef(0, 64);
    send_x(40);
    for (int i = 0; i < 100 && mac_ready; i++) @(negedge clk);
    chk("busy_seen", int'(mac_ready), 0);
    coef_wr_en = 1'b1; coef_wr_addr = 3'd0; coef_wr_data = 8'd0;
    @(negedge clk) coef_wr_en = 1'b0;
    get_y(y);
    chk("busy_write_ignored", y, 40);
    wr_coef(0, 0);
    send_x(40);
    get_y(y);
    chk("idle_write_taken", y, 0);
    wr_coef(0, 64);
    wr_coef(5, 127); wr_coef(6, 127); wr_coef(7, 127);
    send_x(30);
    get_y(y);
    chk("oob_write_ignored", y, 30);

    // reset in the middle of a sample
    do_reset();
    wr_coef(0, 64); wr_coef(1, 64);
    send_x(50);
    get_y(y);
    chk("pre_abort_y", y, 50);
    yv0 = n_yv;
    send_x(30);
    for (int i = 0; i < 100 && mac_ready; i++) @(negedge clk);
    chk("abort_busy_seen", int'(mac_ready), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_mac_reset", int'(mac_reset), 1);
    chk("abort_idle", int'(x_ready), 1);
    reset = 1'b0;
    model_clear();
    repeat (5) @(negedge clk);
    chk("abort_no_y_valid", n_yv - yv0, 0);
    chk("abort_y_out_zero", int'(y_out), 0);
    send_x(20);
    get_y(y);
    chk("abort_coefs_zero", y, 0);
    wr_coef(0, 64); wr_coef(1, 64);
    send_x(10);
    get_y(y);
    chk("abort_history_zero", y, 30);

    // randomized run against the filter model
    do_reset();
    for (int a = 0; a < 5; a++) wr_coef(a, int'($urandom_range(0, 255)) - 128);
    for (int n = 0; n < 30; n++) begin
      int x, ye;
      if ($urandom_range(0, 3) == 0)
        wr_coef(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)) - 128);
      x  = int'($urandom_range(0, 255)) - 128;
      ye = model_step(x);
      send_x(x);
      get_y(y);
      chk($sformatf("rand%0d_y", n), y, ye);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d expected=%0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
